// File: rtl/pc_control.sv
// Program-counter stage: PC register, {Z,V,N} flag register, branch-condition evaluation and HALT sequencing.
// Define PC_BRANCH_STATS_EN to add the saturating taken-branch counter and its br_taken_cnt port.
module pc_control #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        halt,
    input  logic        branch,
    input  logic        branch_reg,
    input  logic [2:0]  ccc,
    input  logic [8:0]  imm9,
    input  logic [15:0] reg_target,
    input  logic [2:0]  flag_en,
    input  logic        alu_z,
    input  logic        alu_v,
    input  logic        alu_n,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic [2:0]  flags,
    output logic        halted
`ifdef PC_BRANCH_STATS_EN
    ,
    output logic [15:0] br_taken_cnt
`endif
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]  state;
    logic [15:0] pc_q;
    logic [2:0]  flags_q;
    logic        cond;
    logic        taken;
    logic        advance;
    logic [15:0] br_offset;
    logic [15:0] next_pc;
    logic [2:0]  alu_flags;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;

    assign flag_z = flags_q[2];
    assign flag_v = flags_q[1];
    assign flag_n = flags_q[0];

    // Conditions always see the flags registered by earlier instructions, never this cycle's ALU result.
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cond = 1'b0;
        case (ccc)
            3'b000:  cond = ~flag_z;
            3'b001:  cond = flag_z;
            3'b010:  cond = ~flag_z & ~flag_n;
            3'b011:  cond = flag_n;
            3'b100:  cond = flag_z | (~flag_z & ~flag_n);
            3'b101:  cond = flag_n | flag_z;
            3'b110:  cond = flag_v;
            default: cond = 1'b1;
        endcase
    end

    assign taken     = branch & cond;
    assign pc_plus2  = pc_q + 16'd2;
    assign br_offset = {{6{imm9[8]}}, imm9, 1'b0};
    assign next_pc   = !taken     ? pc_plus2   :
                       branch_reg ? reg_target :
                                    pc_plus2 + br_offset;

    // A cycle commits only when running and not stalled; halt then suppresses everything but the state change.
    assign advance   = (state == ST_RUN) && !stall;
    assign alu_flags = {alu_z, alu_v, alu_n};

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            pc_q    <= RESET_PC;
            flags_q <= 3'b000;
        end else if (advance) begin
            if (halt) begin
                state <= ST_HALT;
            end else begin
                pc_q    <= next_pc;
                flags_q <= (flag_en & alu_flags) | (~flag_en & flags_q);
            end
        end
    end

`ifdef PC_BRANCH_STATS_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'h0000;
        end else if (advance && !halt && taken && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign br_taken_cnt = cnt_q;
`endif

    assign pc     = pc_q;
    assign flags  = flags_q;
    assign halted = (state == ST_HALT);

endmodule
